// File: rtl/mul_hilo_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_hilo_if
// Purpose  : Operand/function-code bus and HI/LO readout of the multiplier.
// Revision : 1.0  initial release
// ============================================================================
interface mul_hilo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataOut;
  logic             busy;
  logic             done;

  modport master (
    output dataA, dataB, Signal,
    input  dataOut, busy, done
  );

  modport slave (
    input  dataA, dataB, Signal,
    output dataOut, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mul_hilo.sv
`default_nettype none
// ============================================================================
// Module   : mul_hilo
// Purpose  : Shift-add multiplier writing a 2*WIDTH product to HI/LO; MFHI/MFLO
//            read them back. Optional macro MUL_SIGNED_EN adds signed MULT.
// Revision : 1.0  initial release
// ============================================================================
module mul_hilo #(
  parameter int WIDTH = 32
) (
  input  wire logic  clk,
  input  wire logic  reset,
  mul_hilo_if.slave  bus
);

  localparam int         CW       = $clog2(WIDTH) + 1;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               start;
  logic               last;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   data_out;

`ifdef MUL_SIGNED_EN
  localparam logic [5:0] OP_MULT = 6'b011000;

  logic is_mult;
  logic neg_start;
  logic neg;

  // Signed operands run through the unsigned core as magnitudes.
  assign is_mult   = (bus.Signal == OP_MULT);
  assign start     = (state == S_IDLE) && ((bus.Signal == OP_MULTU) || is_mult);
  assign op_a      = (is_mult && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
  assign op_b      = (is_mult && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
  assign neg_start = is_mult && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
  assign result    = neg ? -prod_nxt : prod_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg <= 1'b0;
    end else if (start) begin
      neg <= neg_start;
    end
  end
`else
  assign start  = (state == S_IDLE) && (bus.Signal == OP_MULTU);
  assign op_a   = bus.dataA;
  assign op_b   = bus.dataB;
  assign result = prod_nxt;
`endif

  assign last = (cnt == CW'(WIDTH - 1));

  // One shift-add step: the carry of the upper add becomes the new MSB.
  always_comb begin
    sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {sum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == S_CALC);
    bus.done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand    <= '0;
      prod     <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      data_out <= '0;
    end else begin
      if (start) begin
        mcand <= op_a;
        prod  <= {{WIDTH{1'b0}}, op_b};
        cnt   <= '0;
      end else if (state == S_CALC) begin
        prod <= prod_nxt;
        cnt  <= cnt + CW'(1);
        if (last) begin
          hi <= result[2*WIDTH-1:WIDTH];
          lo <= result[WIDTH-1:0];
        end
      end
      // Reads see the pre-edge HI/LO, even on the write edge.
      case (bus.Signal)
        OP_MFHI: data_out <= hi;
        OP_MFLO: data_out <= lo;
        default: data_out <= data_out;
      endcase
    end
  end

  assign bus.dataOut = data_out;

endmodule
`default_nettype wire

// File: doc/mul_hilo.md
# mul_hilo

Sequential 32-bit multiplier with HI/LO result registers, the execute-stage sibling of the combinational ALU. It receives the same `dataA`/`dataB`/`Signal` operand and function-code bus. On MULTU it computes the 64-bit product in shift-add fashion over WIDTH cycles and writes it to HI/LO. MFHI/MFLO then deliver HI or LO on `dataOut`, which feeds the writeback mux alongside the ALU result.

## Interface
- WIDTH, 32, operand width. The 64-bit product is 2*WIDTH; the iteration counter is clog2(WIDTH)+1 bits.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- dataA  input  WIDTH  multiplicand.
- dataB  input  WIDTH  multiplier.
- Signal  input  6  function code:
  - MULTU = 6'b011001 (25)
  - MFHI = 6'b010000 (16)
  - MFLO = 6'b010010 (18)
  - all other codes are no-ops for this block.
- dataOut  output  WIDTH  registered HI or LO readout.
- busy  output  1  high while a multiply is iterating.
- done  output  1  one-cycle pulse when HI/LO have just been written.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - Signal==MULTU sampled at an edge → latch mcand=dataA, load prod[63:0]={32'b0, dataB}, clear cnt, go to CALC.
- CALC, one iteration per edge:
  - If prod[0]=1: form a 33-bit sum prod[63:32]+mcand; otherwise use the sum {1'b0, prod[63:32]}.
  - Load prod={sum, prod[31:1]}, i.e. a logical right shift of the 65-bit {carry, upper, lower}.
  - cnt increments.
  - On the edge that performs iteration WIDTH, write HI=result[63:32] and LO=result[31:0] in the same edge, then go to DONE.
- DONE: lasts one cycle, then IDLE unconditionally.
- Operand changes on `dataA`/`dataB` after the start edge have no effect.
- MULTU sampled in CALC or DONE is dropped; no queueing.
- MFHI sampled at any edge → dataOut<=HI. MFLO sampled at any edge → dataOut<=LO. Any other code → dataOut holds.
- Reads are legal in every state. During CALC they return the previous product.
- Same-edge read and HI/LO write: the read returns the old HI/LO (nonblocking semantics).
- Reset asserted mid-CALC aborts the operation:
  - state→IDLE
  - HI, LO, dataOut → 0
  - busy, done → 0
  - no done pulse afterwards.

## Timing
- Reset values: dataOut=0, busy=0, done=0, HI=0, LO=0, state IDLE.
- Start edge E0 (MULTU sampled in IDLE): busy=1 from after E0 through edge E0+WIDTH, i.e. 32 cycles high.
- Edge E0+WIDTH: HI/LO written, busy→0, done→1.
- Edge E0+WIDTH+1: done→0. A MULTU sampled at this edge (still in DONE) is dropped.
- Earliest accepted next MULTU: edge E0+WIDTH+2.
- Earliest read of a new result: MFHI/MFLO sampled at E0+WIDTH+1, with dataOut valid after that edge.
- Read latency: 1 cycle from the sampling edge to dataOut.
- busy and done are registered outputs with no combinational path from the inputs.

## Configuration
- MUL_SIGNED_EN defined: adds MULT = 6'b011000 (24), signed multiply, accepted under the same IDLE rules as MULTU.
  - Operands are converted to magnitudes (two's-complement negate if the MSB is set).
  - The unsigned iteration runs with identical timing.
  - At the write edge, the 64-bit result is negated if the operand signs differ.
  - MULTU behaviour is unchanged.
- MUL_SIGNED_EN undefined: code 24 is a no-op. No busy, HI/LO unchanged, no extra sign logic.

## Test plan
- Reset with reset=0, then release; issue MFHI, then MFLO → dataOut=0x00000000 both times; busy=0 and done=0 throughout.
- MULTU with dataA=0x00000003, dataB=0x00000005 → busy high exactly 32 cycles, done pulses 1 cycle; MFLO→0x0000000F; MFHI→0x00000000.
- MULTU with 0xFFFFFFFF × 0xFFFFFFFF → MFHI=0xFFFFFFFE, MFLO=0x00000001 (carry-out path).
- Overlap and stale reads:
  - MULTU 7×6 completes.
  - Then MULTU 0x10000×0x10000.
  - Issue a second MULTU 2×2 at CALC cycle 10 → ignored.
  - MFLO during CALC → 0x0000002A.
  - After done: MFHI=0x00000001, MFLO=0x00000000.
- Mid-operation reset:
  - Complete MULTU 3×5.
  - Start MULTU 9×9, then pull reset low at CALC cycle 16 → busy=0 immediately, no done pulse afterwards.
  - MFLO after release → 0x00000000.
  - A new MULTU 2×3 then → MFLO 0x00000006.
- Signed multiply, code 24 (MULT), dataA=0xFFFFFFFD, dataB=0x00000005:
  - With MUL_SIGNED_EN → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Without MUL_SIGNED_EN → busy stays 0 and HI/LO keep their prior values.
